// File: rtl/seq_onehot_encoder_pkg.sv
// Shared constants and state encoding for the sequential one-hot encoder.
// N/IW are also used by the matching 4-to-16 decoder and its bench.
package seq_onehot_encoder_pkg;

    localparam int N  = 16;
    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/seq_onehot_encoder_prio_enc_lsb.sv
// Combinational priority encoder: lowest set index of a [0:N-1] vector.
// Ports: req (vector, bit i = index i), idx (lowest set index), any (req != 0).
module prio_enc_lsb
    import seq_onehot_encoder_pkg::*;
(
    input  logic [0:N-1]  req,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from the top down so the lowest set index wins last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = i[IW-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_onehot_encoder.sv
// Captures a request vector and emits the index of each set line, lowest first,
// one per Valid/Ready handshake. Ports: Clock, Reset (async, active-high),
// W/Load (capture), Flush (sync abort), Ready (downstream accept),
// Y/Valid (index out), Busy, Zero/Done (1-cycle pulses), Count (popcount).
module seq_onehot_encoder
    import seq_onehot_encoder_pkg::*;
(
    input  logic          Clock,
    input  logic          Reset,
    input  logic [0:N-1]  W,
    input  logic          Load,
    input  logic          Flush,
    input  logic          Ready,
    output logic [IW-1:0] Y,
    output logic          Valid,
    output logic          Busy,
    output logic          Zero,
    output logic          Done,
    output logic [IW:0]   Count
);

    function automatic logic [IW:0] popcount(input logic [0:N-1] v);
        logic [IW:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + {{IW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    state_t        state, state_n;
    logic [0:N-1]  p, p_n, p_clr, enc_in;
    logic [IW-1:0] y_n, enc_idx;
    logic          valid_n, busy_n, zero_n, done_n;
    logic [IW:0]   count_n;
    logic          enc_any;

    // One encoder serves both paths: in IDLE it looks at the incoming
    // vector, in EMIT at what remains after the current index is cleared.
    always_comb begin
        p_clr    = p;
        p_clr[Y] = 1'b0;
        enc_in   = (state == EMIT) ? p_clr : W;
    end

    prio_enc_lsb u_enc (
        .req (enc_in),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        state_n = state;
        p_n     = p;
        y_n     = Y;
        valid_n = Valid;
        busy_n  = Busy;
        zero_n  = 1'b0;
        done_n  = 1'b0;
        count_n = Count;

        if (Flush) begin
            // A same-cycle handshake is consumed but not followed up.
            state_n = IDLE;
            p_n     = '0;
            valid_n = 1'b0;
            busy_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Load) begin
                        count_n = popcount(W);
                        if (enc_any) begin
                            state_n = EMIT;
                            p_n     = W;
                            y_n     = enc_idx;
                            valid_n = 1'b1;
                            busy_n  = 1'b1;
                        end else begin
                            zero_n = 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (Valid && Ready) begin
                        p_n = p_clr;
                        if (enc_any) begin
                            y_n = enc_idx;
                        end else begin
                            state_n = IDLE;
                            valid_n = 1'b0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            p     <= '0;
            Y     <= '0;
            Valid <= 1'b0;
            Busy  <= 1'b0;
            Zero  <= 1'b0;
            Done  <= 1'b0;
            Count <= '0;
        end else begin
            state <= state_n;
            p     <= p_n;
            Y     <= y_n;
            Valid <= valid_n;
            Busy  <= busy_n;
            Zero  <= zero_n;
            Done  <= done_n;
            Count <= count_n;
        end
    end

endmodule

// File: tb/tb_seq_onehot_encoder.sv
// Directed + random bench for seq_onehot_encoder with an index scoreboard
// and a one-hot decoder model for the round-trip check.
module tb_seq_onehot_encoder;
    import seq_onehot_encoder_pkg::*;

    logic          Clock;
    logic          Reset;
    logic [0:N-1]  W;
    logic          Load;
    logic          Flush;
    logic          Ready;
    logic [IW-1:0] Y;
    logic          Valid;
    logic          Busy;
    logic          Zero;
    logic          Done;
    logic [IW:0]   Count;

    int n_assert = 0;
    int n_fail   = 0;
    int sb[$];

    seq_onehot_encoder dut (
        .Clock (Clock),
        .Reset (Reset),
        .W     (W),
        .Load  (Load),
        .Flush (Flush),
        .Ready (Ready),
        .Y     (Y),
        .Valid (Valid),
        .Busy  (Busy),
        .Zero  (Zero),
        .Done  (Done),
        .Count (Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [0:N-1] dec(input logic [IW-1:0] y);
        logic [0:N-1] d;
        d    = '0;
        d[y] = 1'b1;
        return d;
    endfunction

    task automatic load_vec(input logic [0:N-1] w, input string tag);
        if (w != '0) begin
            for (int i = 0; i < N; i++) begin
                if (w[i]) sb.push_back(i);
            end
        end
        W    = w;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        W    = '0;
        chk({tag, "_count"}, 32'(Count), $countones(w));
        chk({tag, "_valid"}, 32'(Valid), 32'(w != '0));
        chk({tag, "_busy"}, 32'(Busy), 32'(w != '0));
        chk({tag, "_zero"}, 32'(Zero), 32'(w == '0));
    endtask

    // mode 0: Ready held high, 1: toggling 1,0,1,0, 2: random
    task automatic drain(input int mode, input logic [0:N-1] w,
                         input string tag);
        int            hs   = 0;
        int            cyc  = 0;
        int            last = -1;
        int            e;
        logic [0:N-1]  acc  = '0;
        logic [IW-1:0] yprev;
        logic          rdy  = 1'b1;
        while (sb.size() > 0 && cyc < 2000) begin
            if (mode == 2) rdy = 1'($urandom_range(0, 1));
            Ready = rdy;
            chk({tag, "_v"}, 32'(Valid), 1);
            chk({tag, "_ysetinw"}, 32'(w[Y]), 1);
            if (rdy) begin
                e = sb.pop_front();
                chk({tag, "_y"}, 32'(Y), e);
                chk({tag, "_asc"}, 32'(int'(Y) > last), 1);
                last = int'(Y);
                acc  = acc | dec(Y);
                hs++;
            end
            yprev = Y;
            tick();
            cyc++;
            if (!rdy) chk({tag, "_hold"}, 32'(Y), 32'(yprev));
            if (mode == 1) rdy = ~rdy;
        end
        Ready = 1'b0;
        if (cyc >= 2000) chk({tag, "_timeout"}, 1, 0);
        chk({tag, "_done"}, 32'(Done), 1);
        chk({tag, "_vlow"}, 32'(Valid), 0);
        chk({tag, "_blow"}, 32'(Busy), 0);
        chk({tag, "_roundtrip"}, 32'(acc), 32'(w));
        chk({tag, "_hs"}, hs, $countones(w));
        chk({tag, "_cnt"}, 32'(Count), $countones(w));
        tick();
        chk({tag, "_done1"}, 32'(Done), 0);
    endtask

    initial begin
        logic [0:N-1] v;
        Reset = 1'b1;
        W     = '0;
        Load  = 1'b0;
        Flush = 1'b0;
        Ready = 1'b0;
        tick();
        tick();
        chk("rst_y", 32'(Y), 0);
        chk("rst_valid", 32'(Valid), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_zero", 32'(Zero), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_count", 32'(Count), 0);
        Reset = 1'b0;

        // 1: reset mid-EMIT, observed before the next clock edge
        load_vec(16'h8001, "t1");
        chk("t1_y0", 32'(Y), 0);
        #2;
        Reset = 1'b1;
        #1;
        chk("t1_async_valid", 32'(Valid), 0);
        chk("t1_async_busy", 32'(Busy), 0);
        chk("t1_async_count", 32'(Count), 0);
        chk("t1_async_y", 32'(Y), 0);
        sb.delete();
        tick();
        Reset = 1'b0;
        load_vec(16'h8001, "t1b");
        drain(0, 16'h8001, "t1b");

        // 2: Y = 2, 13, 15 with Ready high
        v = 16'b0010_0000_0000_0101;
        load_vec(v, "t2");
        chk("t2_first", 32'(Y), 2);
        drain(0, v, "t2");

        // 3: all-zero vector
        load_vec('0, "t3");
        tick();
        chk("t3_zero1", 32'(Zero), 0);
        chk("t3_valid", 32'(Valid), 0);
        chk("t3_busy", 32'(Busy), 0);

        // 4: full vector, toggling Ready
        load_vec(16'hFFFF, "t4");
        drain(1, 16'hFFFF, "t4");

        // Back-to-back: Load accepted in the cycle after Done
        v = '0;
        v[7] = 1'b1;
        load_vec(v, "t4b");
        drain(0, v, "t4b");

        // 5: Load during EMIT ignored, then Flush with handshake on Y=9
        v = '0;
        v[3] = 1'b1;
        v[9] = 1'b1;
        load_vec(v, "t5");
        chk("t5_y3", 32'(Y), 3);
        W     = '0;
        W[0]  = 1'b1;
        Load  = 1'b1;
        Ready = 1'b1;
        chk("t5_hs3", 32'(Y), sb.pop_front());
        tick();
        Load = 1'b0;
        W    = '0;
        chk("t5_y9", 32'(Y), 9);
        chk("t5_cnt_kept", 32'(Count), 2);
        Flush = 1'b1;
        chk("t5_hs9", 32'(Y), sb.pop_front());
        tick();
        Flush = 1'b0;
        Ready = 1'b0;
        chk("t5_valid", 32'(Valid), 0);
        chk("t5_busy", 32'(Busy), 0);
        chk("t5_done", 32'(Done), 0);
        chk("t5_zero", 32'(Zero), 0);
        chk("t5_count", 32'(Count), 2);
        chk("t5_sb", sb.size(), 0);
        tick();
        chk("t5_done1", 32'(Done), 0);
        chk("t5_valid1", 32'(Valid), 0);

        // 6: random vectors with random Ready
        for (int r = 0; r < 1000; r++) begin
            v = 16'($urandom);
            if (r % 50 == 0) v = '0;
            load_vec(v, "t6");
            if (v != '0) drain(2, v, "t6");
            else tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
